uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the Uart8 receiver.
- Consumes `rxDone`/`rxErr`/`out` and queues good bytes in a first-word-fall-through FIFO for a slower consumer.
- Flags overflow and framing errors with sticky bits.
- Decouples the consumer from the 9600-baud byte cadence so no received byte is lost between reads.

---
 rtl/uart_fifo_pkg.sv | 7 +
 rtl/uart_fifo_mem.sv | 27 ++
 rtl/uart_rx_fifo.sv | 127 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared UART buffer constants, used by both the receive and transmit side FIFOs.
package uart_fifo_pkg;

  localparam int UART_WIDTH         = 8;
  localparam int DEFAULT_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the UART FIFOs: registered write port, combinational read port.
// No reset. Contents are only observed through an occupied slot.
module uart_fifo_mem
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH = UART_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Write one entry per accepted byte.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the Uart8 receiver.
// Good bytes go into a first-word-fall-through FIFO.
// Overflow and framing errors are kept as sticky flags.
// Optional: define UART_RX_FIFO_ERR_COUNT_EN to add the saturating errCount output.
module uart_rx_fifo
  import uart_fifo_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_FIFO_DEPTH,  // power of 2, >= 2
  parameter  int WIDTH = UART_WIDTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxDone,
  input  logic             rxErr,
  input  logic [WIDTH-1:0] rxByte,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             frameErr,
`ifdef UART_RX_FIFO_ERR_COUNT_EN
  output logic [7:0]       errCount,
`endif
  input  logic             clrFlags
);

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic             doneQ, errQ, armed;
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [WIDTH-1:0] memRd;
  logic             wrReq, errEdge, rdAcc, wrAcc, dropFull, ferrSet;

  // armed is low for the first clock after reset release. While it is low,
  // doneQ/errQ pick up the receiver's current levels without producing an edge.
  // A byte still held on rxDone across reset is therefore not written twice.
  assign wrReq    = armed & rxDone & ~doneQ;
  assign errEdge  = armed & rxErr  & ~errQ;
  assign rdAcc    = rdEn & ~empty;
  // A full FIFO still accepts a write when a read frees the head slot in the same cycle.
  assign wrAcc    = wrReq & ~rxErr & (~full | rdAcc);
  assign dropFull = wrReq & ~rxErr & full & ~rdAcc;
  // A byte that arrives with rxErr set is discarded.
  // It flags an error even when rxErr was already high (no edge).
  assign ferrSet  = errEdge | (wrReq & rxErr);

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign rdData = empty ? '0 : memRd;

  uart_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(PTR_W)) uMem (
    .clk    (clk),
    .wrEn   (wrAcc),
    .wrAddr (wrPtr),
    .wrData (rxByte),
    .rdAddr (rdPtr),
    .rdData (memRd)
  );

  // Edge-detect registers and the post-reset arming flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      doneQ <= 1'b0;
      errQ  <= 1'b0;
      armed <= 1'b0;
    end else begin
      doneQ <= rxDone;
      errQ  <= rxErr;
      armed <= 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrAcc) wrPtr <= wrPtr + 1'b1;
      if (rdAcc) rdPtr <= rdPtr + 1'b1;
    end
  end

  // Occupancy: unchanged when a write and a read coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case ({wrAcc, rdAcc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags. A set event beats clrFlags in the same cycle, so no event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      if (dropFull)      overflow <= 1'b1;
      else if (clrFlags) overflow <= 1'b0;
      if (ferrSet)       frameErr <= 1'b1;
      else if (clrFlags) frameErr <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_ERR_COUNT_EN
  logic errEvent;
  // errEdge requires rxErr=1 and dropFull requires rxErr=0.
  // The two events never coincide, so a single increment per cycle is enough.
  assign errEvent = errEdge | dropFull;

  // Saturating error counter. clrFlags restarts it at 1 if an event lands on the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              errCount <= 8'd0;
    else if (clrFlags)                      errCount <= errEvent ? 8'd1 : 8'd0;
    else if (errEvent && errCount != 8'hFF) errCount <= errCount + 8'd1;
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a table of single-cycle vectors, plus multi-cycle sequences
// checked against a byte scoreboard.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxDone = 1'b0, rxErr = 1'b0, rdEn = 1'b0, clrFlags = 1'b0;
  logic [7:0] rxByte = 8'h00;
  logic [7:0] rdData;
  logic       empty, full, overflow, frameErr;
  logic [4:0] count;
`ifdef UART_RX_FIFO_ERR_COUNT_EN
  logic [7:0] errCount;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] sbq[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .rxDone   (rxDone),
    .rxErr    (rxErr),
    .rxByte   (rxByte),
    .rdEn     (rdEn),
    .rdData   (rdData),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .frameErr (frameErr),
`ifdef UART_RX_FIFO_ERR_COUNT_EN
    .errCount (errCount),
`endif
    .clrFlags (clrFlags)
  );

  typedef struct {
    logic       done, err, rd, clr;
    logic [7:0] din;
    logic [4:0] cnt;
    logic       emp, ful, ferr;
    logic [7:0] dout;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    sbq.delete();
  endtask

  // Pops the head against the scoreboard.
  task automatic popCheck(input string nm);
    logic [7:0] e;
    if (sbq.size() == 0) begin
      check({nm, "_sbq_empty"}, 32'(1), 32'(0));
    end else begin
      e = sbq.pop_front();
      check({nm, "_nonempty"}, 32'(empty), 32'(0));
      check(nm, 32'(rdData), 32'(e));
    end
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
  endtask

  // One rxDone pulse (2 cycles). When rd is set, the head is popped during the rxDone cycle.
  task automatic pulse(input logic [7:0] b, input bit accept, input bit rd, inout int maxCnt);
    logic [7:0] e;
    rxByte = b;
    rxDone = 1'b1;
    if (rd) begin
      if (sbq.size() == 0) check("pulse_sbq_empty", 32'(1), 32'(0));
      else begin
        e = sbq.pop_front();
        check("pulse_head", 32'(rdData), 32'(e));
      end
      rdEn = 1'b1;
    end
    if (accept) sbq.push_back(b);
    tick();
    rdEn = 1'b0;
    rxDone = 1'b0;
    if (int'(count) > maxCnt) maxCnt = int'(count);
    tick();
  endtask

  initial begin
    int mx;
    //              done  err   rd    clr   din    cnt   emp   ful   ferr  dout   ecnt
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hD5, 5'd1, 1'b0, 1'b0, 1'b0, 8'hD5, 8'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hD5, 5'd1, 1'b0, 1'b0, 1'b0, 8'hD5, 8'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 5'd0, 1'b1, 1'b0, 1'b1, 8'h00, 8'd1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 8'h00, 8'd1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 5'd1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'd0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1, 8'h3C, 8'd1};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'd0};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0};

    // Reset state
    reset = 1'b1;
    tick();
    check("rst_count", 32'(count), 32'(0));
    check("rst_empty", 32'(empty), 32'(1));
    check("rst_full", 32'(full), 32'(0));
    check("rst_rdData", 32'(rdData), 32'(0));
    check("rst_flags", 32'({overflow, frameErr}), 32'(0));
    reset = 1'b0;
    tick();

    // Single-cycle vectors: write, hold, read, framing error, clear, read-on-empty with write
    for (int i = 0; i < 10; i++) begin
      rxDone = vecs[i].done; rxErr = vecs[i].err; rdEn = vecs[i].rd;
      clrFlags = vecs[i].clr; rxByte = vecs[i].din;
      tick();
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].ful));
      check($sformatf("vec%0d_frameErr", i), 32'(frameErr), 32'(vecs[i].ferr));
      check($sformatf("vec%0d_rdData", i), 32'(rdData), 32'(vecs[i].dout));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(0));
`ifdef UART_RX_FIFO_ERR_COUNT_EN
      check($sformatf("vec%0d_errCount", i), 32'(errCount), 32'(vecs[i].ecnt));
`endif
    end
    rxDone = 1'b0; rxErr = 1'b0; rdEn = 1'b0; clrFlags = 1'b0;

    // Single byte, rxDone held for 1000 cycles
    doReset();
    rxByte = 8'b11010101;
    rxDone = 1'b1;
    tick();
    check("hold_first_data", 32'(rdData), 32'hD5);
    check("hold_first_count", 32'(count), 32'(1));
    repeat (999) tick();
    check("hold_count", 32'(count), 32'(1));
    rxDone = 1'b0;
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    check("hold_empty", 32'(empty), 32'(1));
    check("hold_count0", 32'(count), 32'(0));

    // Ordering and wrap: 24 bytes, pop concurrent with every 2nd write
    doReset();
    mx = 0;
    for (int i = 0; i < 24; i++) pulse(8'(i), 1'b1, (i % 2) == 1, mx);
    check("wrap_max_count", 32'(mx), 32'(12));
    check("wrap_count", 32'(count), 32'(12));
    while (sbq.size() > 0) popCheck("wrap_data");
    check("wrap_empty", 32'(empty), 32'(1));

    // Overflow: 17 pulses, the last is dropped
    doReset();
    mx = 0;
    for (int i = 1; i <= 16; i++) pulse(8'(i), 1'b1, 1'b0, mx);
    check("ovf_full", 32'(full), 32'(1));
    check("ovf_pre", 32'(overflow), 32'(0));
    pulse(8'h11, 1'b0, 1'b0, mx);
    check("ovf_set", 32'(overflow), 32'(1));
    check("ovf_count", 32'(count), 32'(16));
`ifdef UART_RX_FIFO_ERR_COUNT_EN
    check("ovf_errCount", 32'(errCount), 32'(1));
`endif
    while (sbq.size() > 0) popCheck("ovf_data");
    check("ovf_sticky", 32'(overflow), 32'(1));
    clrFlags = 1'b1;
    tick();
    clrFlags = 1'b0;
    check("ovf_clr", 32'(overflow), 32'(0));

    // Full with simultaneous read and write
    doReset();
    mx = 0;
    for (int i = 0; i < 16; i++) pulse(8'(8'h20 + i), 1'b1, 1'b0, mx);
    pulse(8'hAA, 1'b1, 1'b1, mx);
    check("fullrw_count", 32'(count), 32'(16));
    check("fullrw_ovf", 32'(overflow), 32'(0));
    while (sbq.size() > 0) popCheck("fullrw_data");
    check("fullrw_empty", 32'(empty), 32'(1));

    // Reset mid-stream with rxDone held
    doReset();
    mx = 0;
    for (int i = 0; i < 5; i++) pulse(8'(8'h60 + i), 1'b1, 1'b0, mx);
    rxErr = 1'b1;
    tick();
    rxErr = 1'b0;
    check("mid_ferr_pre", 32'(frameErr), 32'(1));
    check("mid_count_pre", 32'(count), 32'(5));
    rxByte = 8'h77;
    rxDone = 1'b1;
    reset = 1'b1;
    #2;
    check("mid_async_count", 32'(count), 32'(0));
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("mid_count", 32'(count), 32'(0));
    check("mid_empty", 32'(empty), 32'(1));
    check("mid_flags", 32'({overflow, frameErr}), 32'(0));
    rxDone = 1'b0;
    tick();
    check("mid_count_after", 32'(count), 32'(0));
    sbq.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
